// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hard-wired fetch/decode/execute control FSM for the datapath
// MEM_WAIT_EN: memory steps stall on mem_ready; undefined means every memory step is one cycle.
module control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR_Data,
  input  logic        mem_ready,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rout,
  output logic        BAout,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic [4:0]  alu_instruction,
  output logic [3:0]  step,
  output logic        halted,
  output logic        fault
);

  localparam logic [4:0] ALU_ADD = 5'b00001;

  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_RST = 4'd8, S_HALT = 4'd9, S_FAULT = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_inc, ir_en, y_en, z_en, mar_en, mdr_en, r_en;
    logic       rd, wr, gra, grb, grc, rout, baout;
    logic       pc_sel, zlo_sel, mdr_sel, c_sel;
    logic [4:0] alu;
    logic [3:0] step;
    logic       halted, fault;
  } ctl_t;

  state_t     state, nxt;
  ctl_t       ctl_q, ctl_d;
  logic [4:0] op;
  logic       is_ld, is_ldi, is_st, is_r, mem_go;
  logic       unused_bits;

  assign op     = IR_Data[31:27];
  assign is_ld  = (op == 5'b00000);
  assign is_ldi = (op == 5'b00001);
  assign is_st  = (op == 5'b00010);
  assign is_r   = (op >= 5'b00011) && (op <= 5'b01100);

`ifdef MEM_WAIT_EN
  assign mem_go      = mem_ready;
  assign unused_bits = &{1'b0, IR_Data[26:0]};
`else
  assign mem_go      = 1'b1;
  assign unused_bits = &{1'b0, IR_Data[26:0], mem_ready};
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_RST:   nxt = S_T0;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = mem_go ? S_T2 : S_T1;
      S_T2: begin
        if (is_ld || is_ldi || is_st || is_r) nxt = S_T3;
        else if (op == 5'b11010)              nxt = S_T0;
        else if (op == 5'b11011)              nxt = S_HALT;
        else                                  nxt = S_FAULT;
      end
      S_T3:    nxt = S_T4;
      S_T4:    nxt = S_T5;
      S_T5:    nxt = (is_ld || is_st) ? S_T6 : S_T0;
      S_T6:    nxt = (is_ld && !mem_go) ? S_T6 : S_T7;
      S_T7:    nxt = (is_st && !mem_go) ? S_T7 : S_T0;
      S_HALT:  nxt = S_HALT;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_T0;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the step they describe.
  always_comb begin
    ctl_d = '0;
    case (nxt)
      S_T0: begin
        ctl_d.pc_sel = 1'b1;
        ctl_d.mar_en = 1'b1;
      end
      S_T1: begin
        ctl_d.step   = 4'd1;
        ctl_d.pc_inc = (state != S_T1);
        ctl_d.rd     = 1'b1;
        ctl_d.mdr_en = 1'b1;
      end
      S_T2: begin
        ctl_d.step    = 4'd2;
        ctl_d.mdr_sel = 1'b1;
        ctl_d.ir_en   = 1'b1;
      end
      S_T3: begin
        ctl_d.step  = 4'd3;
        ctl_d.grb   = 1'b1;
        ctl_d.y_en  = 1'b1;
        ctl_d.rout  = is_r;
        ctl_d.baout = !is_r;
      end
      S_T4: begin
        ctl_d.step = 4'd4;
        ctl_d.z_en = 1'b1;
        if (is_r) begin
          ctl_d.grc  = 1'b1;
          ctl_d.rout = 1'b1;
          ctl_d.alu  = op - 5'd2;
        end else begin
          ctl_d.c_sel = 1'b1;
          ctl_d.alu   = ALU_ADD;
        end
      end
      S_T5: begin
        ctl_d.step    = 4'd5;
        ctl_d.zlo_sel = 1'b1;
        if (is_ld || is_st) begin
          ctl_d.mar_en = 1'b1;
        end else begin
          ctl_d.gra  = 1'b1;
          ctl_d.r_en = 1'b1;
        end
      end
      S_T6: begin
        ctl_d.step   = 4'd6;
        ctl_d.mdr_en = 1'b1;
        ctl_d.rd     = is_ld;
        ctl_d.gra    = !is_ld;
        ctl_d.rout   = !is_ld;
      end
      S_T7: begin
        ctl_d.step = 4'd7;
        if (is_ld) begin
          ctl_d.mdr_sel = 1'b1;
          ctl_d.gra     = 1'b1;
          ctl_d.r_en    = 1'b1;
        end else begin
          ctl_d.wr = 1'b1;
        end
      end
      S_HALT: begin
        ctl_d.step   = 4'd15;
        ctl_d.halted = 1'b1;
      end
      S_FAULT: begin
        ctl_d.step  = 4'd15;
        ctl_d.fault = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  // S_RST sits in front of T0 so the first edge after release presents T0 controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RST;
      ctl_q <= '0;
    end else begin
      state <= nxt;
      ctl_q <= ctl_d;
    end
  end

  assign PC_enable           = 1'b0;
  assign PC_increment_enable = ctl_q.pc_inc;
  assign IR_enable           = ctl_q.ir_en;
  assign Y_enable            = ctl_q.y_en;
  assign Z_enable            = ctl_q.z_en;
  assign MAR_enable          = ctl_q.mar_en;
  assign MDR_enable          = ctl_q.mdr_en;
  assign r_enable            = ctl_q.r_en;
  assign read                = ctl_q.rd;
  assign write               = ctl_q.wr;
  assign Gra                 = ctl_q.gra;
  assign Grb                 = ctl_q.grb;
  assign Grc                 = ctl_q.grc;
  assign Rout                = ctl_q.rout;
  assign BAout               = ctl_q.baout;
  assign PC_select           = ctl_q.pc_sel;
  assign Z_LO_select         = ctl_q.zlo_sel;
  assign MDR_select          = ctl_q.mdr_sel;
  assign c_select            = ctl_q.c_sel;
  assign alu_instruction     = ctl_q.alu;
  assign step                = ctl_q.step;
  assign halted              = ctl_q.halted;
  assign fault               = ctl_q.fault;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR_Data = 32'h0;
  logic        mem_ready = 1'b1;
  logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic        MAR_enable, MDR_enable, r_enable, read, write;
  logic        Gra, Grb, Grc, Rout, BAout;
  logic        PC_select, Z_LO_select, MDR_select, c_select;
  logic [4:0]  alu_instruction;
  logic [3:0]  step;
  logic        halted, fault;

  int errors = 0;
  int checks = 0;

  localparam logic [20:0] M_PCEN   = 21'd1 << 20;
  localparam logic [20:0] M_PCINC  = 21'd1 << 19;
  localparam logic [20:0] M_IREN   = 21'd1 << 18;
  localparam logic [20:0] M_YEN    = 21'd1 << 17;
  localparam logic [20:0] M_ZEN    = 21'd1 << 16;
  localparam logic [20:0] M_MAREN  = 21'd1 << 15;
  localparam logic [20:0] M_MDREN  = 21'd1 << 14;
  localparam logic [20:0] M_REN    = 21'd1 << 13;
  localparam logic [20:0] M_RD     = 21'd1 << 12;
  localparam logic [20:0] M_WR     = 21'd1 << 11;
  localparam logic [20:0] M_GRA    = 21'd1 << 10;
  localparam logic [20:0] M_GRB    = 21'd1 << 9;
  localparam logic [20:0] M_GRC    = 21'd1 << 8;
  localparam logic [20:0] M_ROUT   = 21'd1 << 7;
  localparam logic [20:0] M_BA     = 21'd1 << 6;
  localparam logic [20:0] M_PCSEL  = 21'd1 << 5;
  localparam logic [20:0] M_ZLO    = 21'd1 << 4;
  localparam logic [20:0] M_MDRSEL = 21'd1 << 3;
  localparam logic [20:0] M_CSEL   = 21'd1 << 2;
  localparam logic [20:0] M_HALTED = 21'd1 << 1;
  localparam logic [20:0] M_FAULT  = 21'd1;

  logic [29:0] obs;
  assign obs = {step, alu_instruction,
                PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
                MAR_enable, MDR_enable, r_enable, read, write,
                Gra, Grb, Grc, Rout, BAout,
                PC_select, Z_LO_select, MDR_select, c_select, halted, fault};

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .IR_Data(IR_Data), .mem_ready(mem_ready),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rout(Rout), .BAout(BAout), .PC_select(PC_select),
    .Z_LO_select(Z_LO_select), .MDR_select(MDR_select), .c_select(c_select),
    .alu_instruction(alu_instruction), .step(step),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] ev(input logic [3:0] s, input logic [4:0] a,
                                     input logic [20:0] m);
    return {s, a, m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    IR_Data = 32'h0880_0005;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 30'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, 30'h0);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== ev(4'd0, 5'd0, M_PCSEL | M_MAREN)) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, ev(4'd0, 5'd0, M_PCSEL | M_MAREN));
    end
  endtask

  task automatic test_ldi();
    logic [29:0] e [0:5];
    do_reset();
    IR_Data = 32'h0880_0005;
    mem_ready = 1'b1;
    e = '{ev(4'd1, 5'd0, M_PCINC | M_RD | M_MDREN), ev(4'd2, 5'd0, M_MDRSEL | M_IREN),
          ev(4'd3, 5'd0, M_GRB | M_BA | M_YEN), ev(4'd4, 5'd1, M_CSEL | M_ZEN),
          ev(4'd5, 5'd0, M_ZLO | M_GRA | M_REN), ev(4'd0, 5'd0, M_PCSEL | M_MAREN)};
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL ldi[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_rtype_sub();
    logic [29:0] e [0:5];
    logic        mr [0:5];
    do_reset();
    IR_Data = 32'h2000_00AB;
    mr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e = '{ev(4'd1, 5'd0, M_PCINC | M_RD | M_MDREN), ev(4'd2, 5'd0, M_MDRSEL | M_IREN),
          ev(4'd3, 5'd0, M_GRB | M_ROUT | M_YEN), ev(4'd4, 5'd2, M_GRC | M_ROUT | M_ZEN),
          ev(4'd5, 5'd0, M_ZLO | M_GRA | M_REN), ev(4'd0, 5'd0, M_PCSEL | M_MAREN)};
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL rtype_sub[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [29:0] e [0:7];
    do_reset();
    IR_Data = 32'h1000_0004;
    mem_ready = 1'b1;
    e = '{ev(4'd1, 5'd0, M_PCINC | M_RD | M_MDREN), ev(4'd2, 5'd0, M_MDRSEL | M_IREN),
          ev(4'd3, 5'd0, M_GRB | M_BA | M_YEN), ev(4'd4, 5'd1, M_CSEL | M_ZEN),
          ev(4'd5, 5'd0, M_ZLO | M_MAREN), ev(4'd6, 5'd0, M_GRA | M_ROUT | M_MDREN),
          ev(4'd7, 5'd0, M_WR), ev(4'd0, 5'd0, M_PCSEL | M_MAREN)};
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL store[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_nop();
    logic [29:0] e [0:2];
    do_reset();
    IR_Data = 32'hD000_0000;
    mem_ready = 1'b1;
    e = '{ev(4'd1, 5'd0, M_PCINC | M_RD | M_MDREN), ev(4'd2, 5'd0, M_MDRSEL | M_IREN),
          ev(4'd0, 5'd0, M_PCSEL | M_MAREN)};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL nop[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_ld_wait();
    logic [29:0] e [0:9];
    logic        mr [0:9];
    int          n;
    do_reset();
    IR_Data = 32'h0000_0010;
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    e[0] = ev(4'd1, 5'd0, M_PCINC | M_RD | M_MDREN);
    e[1] = ev(4'd2, 5'd0, M_MDRSEL | M_IREN);
    e[2] = ev(4'd3, 5'd0, M_GRB | M_BA | M_YEN);
    e[3] = ev(4'd4, 5'd1, M_CSEL | M_ZEN);
    e[4] = ev(4'd5, 5'd0, M_ZLO | M_MAREN);
    e[5] = ev(4'd6, 5'd0, M_RD | M_MDREN);
`ifdef MEM_WAIT_EN
    n = 10;
    e[6] = ev(4'd6, 5'd0, M_RD | M_MDREN);
    e[7] = ev(4'd6, 5'd0, M_RD | M_MDREN);
    e[8] = ev(4'd7, 5'd0, M_MDRSEL | M_GRA | M_REN);
    e[9] = ev(4'd0, 5'd0, M_PCSEL | M_MAREN);
`else
    n = 8;
    e[6] = ev(4'd7, 5'd0, M_MDRSEL | M_GRA | M_REN);
    e[7] = ev(4'd0, 5'd0, M_PCSEL | M_MAREN);
    e[8] = 30'h0;
    e[9] = 30'h0;
`endif
    for (int i = 0; i < n; i++) begin
      mem_ready = mr[i];
      tick();
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL ld_wait[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_midwait();
    logic [3:0] exp_step [0:2];
    int         pulses;
    do_reset();
    IR_Data = 32'h0000_0010;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    mem_ready = 1'b0;
    tick();
    checks++;
`ifdef MEM_WAIT_EN
    if (step !== 4'd6) begin
`else
    if (step !== 4'd7) begin
`endif
      errors++;
      $display("FAIL midwait_pre_step: got %0d", step);
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    tick();
    checks++;
    if (obs !== 30'h0) begin
      errors++;
      $display("FAIL midwait_reset: got %h expected %h", obs, 30'h0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== ev(4'd0, 5'd0, M_PCSEL | M_MAREN)) begin
      errors++;
      $display("FAIL midwait_t0: got %h expected %h", obs, ev(4'd0, 5'd0, M_PCSEL | M_MAREN));
    end
`ifdef MEM_WAIT_EN
    exp_step = '{4'd1, 4'd1, 4'd2};
`else
    exp_step = '{4'd1, 4'd2, 4'd3};
`endif
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      tick();
      if (PC_increment_enable === 1'b1) pulses++;
      checks++;
      if (step !== exp_step[i]) begin
        errors++;
        $display("FAIL midwait_fetch_step[%0d]: got %0d expected %0d", i, step, exp_step[i]);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL midwait_pcinc_pulses: got %0d expected 1", pulses);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_halt_fault();
    do_reset();
    IR_Data = 32'hD800_1234;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    checks++;
    if (obs !== ev(4'd2, 5'd0, M_MDRSEL | M_IREN)) begin
      errors++;
      $display("FAIL halt_t2: got %h expected %h", obs, ev(4'd2, 5'd0, M_MDRSEL | M_IREN));
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tick();
      checks++;
      if (obs !== ev(4'd15, 5'd0, M_HALTED)) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %h expected %h", i, obs, ev(4'd15, 5'd0, M_HALTED));
      end
    end
    mem_ready = 1'b1;
    do_reset();
    IR_Data = 32'hF800_0000;
    for (int i = 0; i < 2; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== ev(4'd15, 5'd0, M_FAULT)) begin
        errors++;
        $display("FAIL fault[%0d]: got %h expected %h", i, obs, ev(4'd15, 5'd0, M_FAULT));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_rtype_sub();
    test_store();
    test_nop();
    test_ld_wait();
    test_reset_midwait();
    test_halt_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
